// File: rtl/div3_serial_if.sv
// Valid/ready bus for the serial divisible-by-3 unit: one word in, one
// word/remainder/flag result out.
interface div3_serial_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_rem;
    logic              out_div;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_rem, out_div
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_rem, out_div
    );
endinterface

// File: rtl/div3_serial.sv
// Bit-serial word mod 3 (MSB first) with a saturating count of delivered
// divisible results. One word in flight; DATA_W+2 cycles minimum per word.
module div3_serial #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    div3_serial_if.slave     bus,
    output logic [CNT_W-1:0] div_cnt
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0]    BIT_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0]    BIT_ONE  = BW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        rem;
    logic [1:0]        rem_nxt;
    logic [1:0]        rem_q;
    logic              div_q;
    logic [BW-1:0]     bitcnt;

    // rem_next = (2*rem + bit) mod 3; rem never reaches 3
    always_comb begin
        rem_nxt = 2'd0;
        case ({rem, shreg[DATA_W-1]})
            3'b000:  rem_nxt = 2'd0;
            3'b001:  rem_nxt = 2'd1;
            3'b010:  rem_nxt = 2'd2;
            3'b011:  rem_nxt = 2'd0;
            3'b100:  rem_nxt = 2'd1;
            3'b101:  rem_nxt = 2'd2;
            default: rem_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            data_q  <= '0;
            rem     <= 2'd0;
            rem_q   <= 2'd0;
            div_q   <= 1'b0;
            bitcnt  <= '0;
            div_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg  <= bus.in_data;
                        data_q <= bus.in_data;
                        rem    <= 2'd0;
                        bitcnt <= BIT_LAST;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    rem    <= rem_nxt;
                    shreg  <= shreg << 1;
                    bitcnt <= bitcnt - BIT_ONE;
                    if (bitcnt == '0) begin
                        rem_q <= rem_nxt;
                        div_q <= (rem_nxt == 2'd0);
                        state <= DONE;
                    end
                end
                DONE: begin
                    // The accept of the next word waits for IDLE on the following cycle
                    if (bus.out_ready) begin
                        if (div_q && (div_cnt != '1))
                            div_cnt <= div_cnt + CNT_ONE;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = data_q;
    assign bus.out_rem   = rem_q;
    assign bus.out_div   = div_q;
endmodule

// File: doc/div3_serial.md
Name: div3_serial

Overview:
- Sequential divisible-by-3 unit. It accepts one DATA_W-bit word per valid/ready handshake and computes word mod 3 bit-serially, MSB first, using a 3-state remainder FSM.
- It returns the word together with its remainder and a divisibility flag, and keeps a running count of divisible words.
- It sits in the divisibility datapath as the multi-cycle, area-cheap stage that consumers take the remainder/flag from.

Parameters:
- DATA_W, 8, width of the input word; valid for DATA_W >= 1.
- CNT_W, 16, width of the divisible-word counter.

Ports:
- clk, input, 1, single clock; all logic on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, upstream word valid.
- in_ready, output, 1, block can accept a word.
- in_data, input, DATA_W, word to test.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts result.
- out_data, output, DATA_W, copy of the accepted word.
- out_rem, output, 2, word mod 3 (0, 1 or 2; never 3).
- out_div, output, 1, 1 when out_rem == 0.
- div_cnt, output, CNT_W, number of delivered results with out_div = 1, saturating.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_rem = 0, out_div = 0, div_cnt = 0.
  - Reset overrides every other event in the same cycle.
  - Reset mid-SHIFT or mid-DONE abandons the word; no result is produced and div_cnt is not incremented.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - If in_valid: capture in_data into the shift register and the out_data register, set rem = 0 and bit counter = DATA_W-1, go to SHIFT.
  - SHIFT:
    - in_ready = 0.
    - Each cycle: rem_next = (2*rem + shreg[DATA_W-1]) mod 3, computed with the table below. Then shift shreg left by 1 and decrement the counter.
    - Remainder table (rem, bit -> rem_next): 0,0 -> 0; 0,1 -> 1; 1,0 -> 2; 1,1 -> 0; 2,0 -> 1; 2,1 -> 2.
    - After processing bit 0 (counter was 0), go to DONE with out_rem = final rem.
    - Exactly DATA_W cycles are spent in SHIFT.
  - DONE:
    - out_valid = 1.
    - out_data, out_rem and out_div are held stable until the handshake.
    - in_ready = 0; in_valid is ignored.
    - On out_valid & out_ready: if out_div = 1, div_cnt increments (it saturates at 2^CNT_W-1 and does not wrap). Then go to IDLE.
- Output registers:
  - out_rem and out_div are registered outputs.
  - Outside DONE their values are don't-care to consumers but must not be X after reset.
- Latency and throughput:
  - The accept edge is T. out_valid rises after edge T+DATA_W.
  - Minimum period between accepts is DATA_W+2 cycles (1 in IDLE, DATA_W in SHIFT, 1 in DONE with out_ready=1).
- Handshake rules:
  - in_ready is a function of state only, with no combinational path from out_ready.
  - There is no accept in the same cycle as a DONE handshake; the next accept happens in IDLE on the following cycle.
- Arithmetic:
  - rem is 2 bits and never holds 3.
  - The result equals in_data mod 3 treating in_data as unsigned.
  - in_data = 0 gives rem 0 and div 1.
- DATA_W = 1: one SHIFT cycle; the result is 0 or 1.
- in_valid asserted while not in IDLE: ignored, no data loss to the block. Upstream must hold the word until it sees in_ready.

Test Plan:
- Basic values, DATA_W=8, out_ready=1:
  - in_data=6 -> 8 cycles after accept: out_rem=0, out_div=1, out_data=6.
  - in_data=32 -> out_rem=2, out_div=0.
  - in_data=255 -> out_rem=0, out_div=1.
  - in_data=1 -> out_rem=1.
  - div_cnt=2 after all four words.
- Exhaustive sweep: in_data = 0..255 back-to-back with in_valid held high.
  - Every result matches the reference model value mod 3.
  - Accepts are spaced exactly 10 cycles apart.
  - Final div_cnt = 86.
- Backpressure:
  - Setup: in_data=170 with out_ready=0 for 5 cycles after out_valid rises.
  - Response: out_valid stays 1; out_data=170, out_rem=2 and out_div=0 are stable; in_ready=0; a second word presented on in_valid is not accepted.
  - After out_ready=1: handshake, then IDLE, then the second word is accepted.
- Reset mid-operation:
  - Setup: rst pulsed on the 3rd SHIFT cycle of in_data=9.
  - Response: next cycle in_ready=1, out_valid=0, div_cnt=0; no result for 9 is ever produced.
- Counter saturation:
  - Setup: CNT_W=2, feed five words divisible by 3 (0, 3, 6, 9, 12).
  - Response: div_cnt reads 1, 2, 3, 3, 3 after each output handshake.
- Zero and DATA_W=1 corner:
  - in_data=0 -> out_rem=0, out_div=1.
  - Separate instance with DATA_W=1, in_data=1 -> out_valid 1 cycle after accept, out_rem=1, out_div=0.
